// File: rtl/riscv_aes_pkg.sv
// Shared types and constants for the AES coprocessor controller.
// Holds the command selects, the FSM states and the writeback geometry.
package riscv_aes_pkg;

  typedef enum logic [1:0] {
    CMD_DATA  = 2'd0,
    CMD_KEY   = 2'd1,
    CMD_START = 2'd2,
    CMD_ADDR  = 2'd3
  } cmd_sel_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_AES,
    WB,
    FIN
  } state_e;

  localparam int WB_WORDS    = 4;
  localparam int WORD_STRIDE = 4;

endpackage

// File: rtl/riscv_aes_wb_seq.sv
// Writeback sequencer: captures the ciphertext and its base address, then
// streams WB_WORDS bus writes (most significant word first) with req/gnt.
module riscv_aes_wb_seq
  import riscv_aes_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           capture,
  input  logic [WB_WORDS*DATA_WIDTH-1:0] aes_data,
  input  logic [31:0]                    aes_addr,
  input  logic                           active,
  input  logic                           mem_gnt,
  output logic                           mem_req,
  output logic [31:0]                    mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_wdata,
  output logic                           last_gnt
);

  localparam int K_W = $clog2(WB_WORDS);

  logic [K_W-1:0]                 k;
  logic [WB_WORDS*DATA_WIDTH-1:0] data_q;
  logic [31:0]                    addr_q;
  logic                           gnt_ok;

  // A grant only counts while a request is actually being presented.
  assign mem_req  = active;
  assign gnt_ok   = active & mem_gnt;
  assign last_gnt = gnt_ok & (k == K_W'(WB_WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k      <= '0;
      data_q <= '0;
      addr_q <= '0;
    end else if (capture) begin
      k      <= '0;
      data_q <= aes_data;
      addr_q <= aes_addr;
    end else if (gnt_ok) begin
      k <= last_gnt ? '0 : k + 1'b1;
    end
  end

  // Address arithmetic wraps naturally at 2^32.
  assign mem_addr  = addr_q + 32'(int'(k) * WORD_STRIDE);
  assign mem_wdata = data_q[DATA_WIDTH*(WB_WORDS-1-int'(k)) +: DATA_WIDTH];

endmodule

// File: rtl/riscv_aes_ctrl.sv
// AES coprocessor controller: decodes core commands into register-file writes
// or a cipher start, waits for completion with a timeout, then writes back.
module riscv_aes_ctrl
  import riscv_aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_valid_i,
  input  logic [1:0]                     cmd_sel_i,
  input  logic [1:0]                     cmd_idx_i,
  input  logic [DATA_WIDTH-1:0]          cmd_wdata_i,
  output logic                           cmd_ready_o,
  output logic                           busy_o,
  output logic                           rf_wen_o,
  output logic [1:0]                     rf_sel_o,
  output logic [1:0]                     rf_waddr_o,
  output logic [DATA_WIDTH-1:0]          rf_wdata_o,
  output logic                           aes_start_o,
  input  logic                           aes_done_i,
  input  logic [WB_WORDS*DATA_WIDTH-1:0] aes_data_i,
  input  logic [31:0]                    aes_addr_i,
  output logic                           mem_req_o,
  output logic [31:0]                    mem_addr_o,
  output logic [DATA_WIDTH-1:0]          mem_wdata_o,
  input  logic                           mem_gnt_i,
  output logic                           done_o,
  output logic                           err_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic             accept, is_start, expired, capture, wb_last;

  // Ready is a pure function of state, so acceptance never loops through the FSM.
  assign accept   = cmd_valid_i & (state == IDLE);
  assign is_start = (cmd_sel_e'(cmd_sel_i) == CMD_START);
  assign expired  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign capture  = (state == WAIT_AES) & aes_done_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      aes_start_o <= 1'b0;
      rf_wen_o    <= 1'b0;
      rf_sel_o    <= '0;
      rf_waddr_o  <= '0;
      rf_wdata_o  <= '0;
    end else begin
      state       <= state_n;
      cnt         <= (state == WAIT_AES && state_n == WAIT_AES) ? cnt + 1'b1 : '0;
      aes_start_o <= accept & is_start;
      rf_wen_o    <= accept & ~is_start;
      if (accept & ~is_start) begin
        rf_sel_o   <= cmd_sel_i;
        rf_waddr_o <= cmd_idx_i;
        rf_wdata_o <= cmd_wdata_i;
      end
    end
  end

  // Completion takes priority over expiry when both land in the same cycle.
  always_comb begin
    state_n     = state;
    cmd_ready_o = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    err_o       = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (accept && is_start) state_n = WAIT_AES;
      end
      WAIT_AES: begin
        if (aes_done_i) begin
          state_n = WB;
        end else if (expired) begin
          err_o   = 1'b1;
          state_n = IDLE;
        end
      end
      WB: begin
        if (wb_last) state_n = FIN;
      end
      FIN: begin
        done_o  = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  riscv_aes_wb_seq #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wb_seq (
    .clk       (clk),
    .rst       (rst),
    .capture   (capture),
    .aes_data  (aes_data_i),
    .aes_addr  (aes_addr_i),
    .active    (state == WB),
    .mem_gnt   (mem_gnt_i),
    .mem_req   (mem_req_o),
    .mem_addr  (mem_addr_o),
    .mem_wdata (mem_wdata_o),
    .last_gnt  (wb_last)
  );

endmodule

// File: tb/tb_riscv_aes_ctrl.sv
// Directed bench for riscv_aes_ctrl: transaction scoreboard checked every
// cycle on the falling edge, plus literal expectations per scenario.
module tb_riscv_aes_ctrl;
  import riscv_aes_pkg::*;

  localparam int T = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid_i = 1'b0;
  logic [1:0]   cmd_sel_i = '0;
  logic [1:0]   cmd_idx_i = '0;
  logic [31:0]  cmd_wdata_i = '0;
  logic         cmd_ready_o, busy_o, rf_wen_o, aes_start_o;
  logic [1:0]   rf_sel_o, rf_waddr_o;
  logic [31:0]  rf_wdata_o;
  logic         aes_done_i = 1'b0;
  logic [127:0] aes_data_i = '0;
  logic [31:0]  aes_addr_i = '0;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o, mem_wdata_o;
  logic         mem_gnt_i = 1'b0;
  logic         done_o, err_o;

  always #5 clk = ~clk;

  riscv_aes_ctrl #(.TIMEOUT_CYCLES(T), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_sel_i(cmd_sel_i), .cmd_idx_i(cmd_idx_i),
    .cmd_wdata_i(cmd_wdata_i), .cmd_ready_o(cmd_ready_o), .busy_o(busy_o),
    .rf_wen_o(rf_wen_o), .rf_sel_o(rf_sel_o), .rf_waddr_o(rf_waddr_o),
    .rf_wdata_o(rf_wdata_o), .aes_start_o(aes_start_o),
    .aes_done_i(aes_done_i), .aes_data_i(aes_data_i), .aes_addr_i(aes_addr_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .done_o(done_o), .err_o(err_o)
  );

  int checks = 0;
  int failures = 0;

  // Expected transactions: rf writes {sel,idx,data}, bus writes {addr,data}.
  logic [35:0] exp_rf[$];
  logic [63:0] exp_mem[$];
  int exp_done = 0, exp_err = 0, exp_start = 0;

  logic [127:0] d1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  logic [127:0] d2 = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
  logic [31:0]  wrap_addr[4] = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004};
  logic [31:0]  d1_words[4]  = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] sel, input logic [1:0] idx, input logic [31:0] wd);
    cmd_valid_i = 1'b1;
    cmd_sel_i   = sel;
    cmd_idx_i   = idx;
    cmd_wdata_i = wd;
    if (sel == 2'd2) exp_start++;
    else exp_rf.push_back({sel, idx, wd});
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic expect_op(input logic [31:0] a, input logic [127:0] d);
    for (int k = 0; k < 4; k++) exp_mem.push_back({a + 32'(4 * k), d[127 - 32*k -: 32]});
    exp_done++;
  endtask

  task automatic aes_finish(input logic [31:0] a, input logic [127:0] d);
    aes_done_i = 1'b1;
    aes_data_i = d;
    aes_addr_i = a;
    tick();
    aes_done_i = 1'b0;
  endtask

  // Per-cycle scoreboard compare
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;
  always @(negedge clk) begin
    chk("busy_vs_ready", {63'b0, busy_o}, {63'b0, !cmd_ready_o});
    if (rf_wen_o) begin
      chk("rf_expected", {63'b0, exp_rf.size() != 0}, 64'd1);
      if (exp_rf.size() != 0) chk("rf_write", {28'b0, rf_sel_o, rf_waddr_o, rf_wdata_o}, {28'b0, exp_rf.pop_front()});
    end
    if (aes_start_o) begin
      chk("start_expected", {63'b0, exp_start > 0}, 64'd1);
      if (exp_start > 0) exp_start--;
    end
    if (prev_stall && mem_req_o) begin
      chk("hold_addr", {32'b0, mem_addr_o}, {32'b0, prev_addr});
      chk("hold_wdata", {32'b0, mem_wdata_o}, {32'b0, prev_wdata});
    end
    if (mem_req_o && mem_gnt_i) begin
      chk("mem_expected", {63'b0, exp_mem.size() != 0}, 64'd1);
      if (exp_mem.size() != 0) chk("mem_write", {mem_addr_o, mem_wdata_o}, exp_mem.pop_front());
    end
    if (done_o) begin
      chk("done_expected", {63'b0, exp_done > 0 && exp_mem.size() == 0}, 64'd1);
      if (exp_done > 0) exp_done--;
    end
    if (err_o) begin
      chk("err_expected", {63'b0, exp_err > 0 && !mem_req_o}, 64'd1);
      if (exp_err > 0) exp_err--;
    end
    prev_stall = mem_req_o && !mem_gnt_i;
    prev_addr  = mem_addr_o;
    prev_wdata = mem_wdata_o;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_ready", {63'b0, cmd_ready_o}, 64'd1);
    chk("rst_outputs", {57'b0, busy_o, rf_wen_o, aes_start_o, mem_req_o, done_o, err_o, 1'b0}, 64'd0);
    chk("rst_rf_data", {32'b0, rf_wdata_o}, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {63'b0, cmd_ready_o}, 64'd1);

    // Register-file writes
    send(2'd0, 2'd1, 32'hDEAFBABE);
    chk("rf_wen_pulse", {63'b0, rf_wen_o}, 64'd1);
    chk("rf_fields", {28'b0, rf_sel_o, rf_waddr_o, rf_wdata_o}, {28'b0, 2'd0, 2'd1, 32'hDEAFBABE});
    tick();
    chk("rf_wen_one_cycle", {63'b0, rf_wen_o}, 64'd0);
    send(2'd1, 2'd3, 32'h01234567);
    send(2'd3, 2'd0, 32'h00000100);
    tick();

    // Normal operation, grant tied high
    expect_op(32'h100, d1);
    mem_gnt_i = 1'b1;
    send(2'd2, 2'd0, 32'h0);
    chk("start_pulse", {62'b0, aes_start_o, busy_o}, 64'd3);
    tick();
    chk("start_one_cycle", {63'b0, aes_start_o}, 64'd0);
    repeat (8) tick();
    aes_finish(32'h100, d1);
    for (int k = 0; k < 4; k++) begin
      chk("normal_addr", {31'b0, mem_req_o, mem_addr_o}, {31'b0, 1'b1, 32'h100 + 32'(4 * k)});
      chk("normal_data", {32'b0, mem_wdata_o}, {32'b0, d1_words[k]});
      tick();
    end
    chk("normal_done", {62'b0, done_o, busy_o}, 64'd3);
    tick();
    chk("normal_idle", {61'b0, done_o, busy_o, mem_req_o}, 64'd0);

    // Backpressure on word 1
    expect_op(32'h200, d2);
    send(2'd2, 2'd0, 32'h0);
    repeat (3) tick();
    aes_finish(32'h200, d2);
    chk("bp_w0", {32'b0, mem_addr_o}, 64'h200);
    tick();
    mem_gnt_i = 1'b0;
    repeat (3) begin
      #1;
      chk("bp_hold_addr", {31'b0, mem_req_o, mem_addr_o}, {31'b0, 1'b1, 32'h204});
      chk("bp_hold_data", {32'b0, mem_wdata_o}, 64'hB0B1B2B3);
      tick();
    end
    mem_gnt_i = 1'b1;
    chk("bp_w1_grant", {32'b0, mem_addr_o}, 64'h204);
    tick();
    chk("bp_w2", {32'b0, mem_addr_o}, 64'h208);
    tick();
    chk("bp_w3", {32'b0, mem_wdata_o}, 64'hD0D1D2D3);
    tick();
    chk("bp_done", {63'b0, done_o}, 64'd1);
    tick();

    // Timeout without completion
    exp_err++;
    send(2'd2, 2'd0, 32'h0);
    repeat (T - 2) tick();
    chk("to_before", {63'b0, err_o}, 64'd0);
    tick();
    chk("to_err", {62'b0, err_o, mem_req_o}, 64'd2);
    tick();
    chk("to_idle", {61'b0, cmd_ready_o, busy_o, err_o}, 64'd4);

    // Stray completion while idle is ignored
    aes_finish(32'h900, d2);
    chk("stray_done", {62'b0, mem_req_o, busy_o}, 64'd0);

    // Completion exactly at expiry
    expect_op(32'h300, d1);
    send(2'd2, 2'd0, 32'h0);
    repeat (T - 1) tick();
    aes_done_i = 1'b1;
    aes_data_i = d1;
    aes_addr_i = 32'h300;
    #1;
    chk("expiry_done_no_err", {63'b0, err_o}, 64'd0);
    tick();
    aes_done_i = 1'b0;
    chk("expiry_wb", {31'b0, mem_req_o, mem_addr_o}, {31'b0, 1'b1, 32'h300});
    repeat (4) tick();
    chk("expiry_done", {63'b0, done_o}, 64'd1);
    tick();

    // Address wrap
    expect_op(32'hFFFFFFF8, d2);
    send(2'd2, 2'd0, 32'h0);
    tick();
    aes_finish(32'hFFFFFFF8, d2);
    for (int k = 0; k < 4; k++) begin
      chk("wrap_addr", {32'b0, mem_addr_o}, {32'b0, wrap_addr[k]});
      tick();
    end
    chk("wrap_done", {63'b0, done_o}, 64'd1);
    tick();

    // Command while busy is not accepted
    send(2'd2, 2'd0, 32'h0);
    cmd_valid_i = 1'b1;
    cmd_sel_i   = 2'd0;
    cmd_idx_i   = 2'd2;
    cmd_wdata_i = 32'hBAD0BAD0;
    #1;
    chk("busy_not_ready", {63'b0, cmd_ready_o}, 64'd0);
    tick();
    chk("busy_no_rf", {63'b0, rf_wen_o}, 64'd0);
    cmd_valid_i = 1'b0;
    expect_op(32'h400, d1);
    aes_finish(32'h400, d1);
    repeat (4) tick();
    chk("gate_done", {63'b0, done_o}, 64'd1);
    tick();

    // Reset during word 2, then a clean operation
    expect_op(32'h500, d2);
    send(2'd2, 2'd0, 32'h0);
    tick();
    aes_finish(32'h500, d2);
    tick();
    tick();
    chk("rst_wb_w2", {31'b0, mem_req_o, mem_addr_o}, {31'b0, 1'b1, 32'h508});
    rst = 1'b1;
    exp_mem.delete();
    exp_done = 0;
    #1;
    chk("rst_wb_drop", {60'b0, mem_req_o, busy_o, done_o, cmd_ready_o}, 64'd1);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_no_done", {63'b0, done_o}, 64'd0);
    expect_op(32'h600, d1);
    send(2'd2, 2'd0, 32'h0);
    tick();
    aes_finish(32'h600, d1);
    repeat (4) tick();
    chk("post_rst_done", {63'b0, done_o}, 64'd1);
    tick();
    tick();

    chk("left_mem", 64'(exp_mem.size()), 64'd0);
    chk("left_rf", 64'(exp_rf.size()), 64'd0);
    chk("left_events", {32'(exp_done + exp_err), 32'(exp_start)}, 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
